requant_pack: RTL and testbench

REQUANT_PACK -- requirements
Module: requant_pack

---
 rtl/fomo_pkg.sv | 44 ++++
 rtl/requant_core.sv | 121 ++++++++++++
 rtl/requant_pack.sv | 116 +++++++++++
 tb/tb_requant_pack.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fomo_pkg.sv
// ============================================================================
// fomo_pkg : shared widths, requant config struct and rounding helper
// Rev 1.0  : initial release
// ============================================================================
`default_nettype none

package fomo_pkg;

    localparam int ACC_W   = 32;
    localparam int LANE_W  = 8;
    localparam int LANES   = 4;
    localparam int SHIFT_W = 6;
    localparam int OFF_W   = 9;

    typedef struct packed {
        logic [ACC_W-1:0]   bias;
        logic [ACC_W-1:0]   mult;
        logic [SHIFT_W-1:0] shift;
        logic [OFF_W-1:0]   out_off;
        logic [LANE_W-1:0]  act_min;
        logic [LANE_W-1:0]  act_max;
    } requant_cfg_t;

    // Round-half-away-from-zero arithmetic right shift by r bits.
    function automatic logic signed [ACC_W-1:0] round_rshift(
        input logic signed [ACC_W-1:0] y,
        input logic [4:0]              r
    );
        logic [ACC_W-1:0]        mask;
        logic [ACC_W-1:0]        rem;
        logic [ACC_W-1:0]        thr;
        logic signed [ACC_W-1:0] shifted;
        logic signed [ACC_W-1:0] inc;
        mask    = (32'd1 << r) - 32'd1;
        rem     = y & mask;
        thr     = (mask >> 1) + {31'd0, y[ACC_W-1]};
        shifted = y >>> r;
        inc     = {31'd0, (rem > thr)};
        return shifted + inc;
    endfunction

endpackage

`default_nettype wire

// File: rtl/requant_core.sv
// ============================================================================
// requant_core : three-stage requantisation (bias/shift/mul, round, clamp)
// Rev 1.0      : initial release
// ============================================================================
`default_nettype none

module requant_core
    import fomo_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  requant_cfg_t      cfg,
    input  logic              in_valid,
    input  logic [ACC_W-1:0]  in_acc,
    input  logic              in_last,
    output logic              out_valid,
    output logic [LANE_W-1:0] out_byte,
    output logic              out_last,
    output logic              stage_busy
);

    localparam logic [63:0] NUDGE_POS = 64'h0000_0000_4000_0000;
    localparam logic [63:0] NUDGE_NEG = 64'hFFFF_FFFF_C000_0001;

    logic [ACC_W-1:0]        biased;
    logic [4:0]              lshift;
    logic [ACC_W-1:0]        shifted;
    logic signed [63:0]      prod_c;
    logic                    sat_c;

    logic                    s1_valid;
    logic                    s1_last;
    logic                    s1_sat;
    logic signed [63:0]      s1_prod;

    logic signed [63:0]      sum;
    logic signed [ACC_W-1:0] high;
    logic [4:0]              rshift;
    logic signed [ACC_W-1:0] rounded;

    logic                    s2_valid;
    logic                    s2_last;
    logic signed [ACC_W-1:0] s2_res;

    logic signed [33:0]      z;
    logic signed [33:0]      lo;
    logic signed [33:0]      hi;
    logic [LANE_W-1:0]       byte_c;

    logic                    s3_valid;
    logic                    s3_last;
    logic [LANE_W-1:0]       s3_byte;

    logic                    unused_sum_bits;

    always_comb begin
        biased  = in_acc + cfg.bias;
        lshift  = cfg.shift[SHIFT_W-1] ? 5'd0 : cfg.shift[4:0];
        shifted = biased << lshift;
        prod_c  = $signed({{ACC_W{shifted[ACC_W-1]}}, shifted}) *
                  $signed({{ACC_W{cfg.mult[ACC_W-1]}}, cfg.mult});
        sat_c   = (shifted == 32'h8000_0000) && (cfg.mult == 32'h8000_0000);
    end

    // Doubling high multiply keeps bits [62:31] of the nudged product.
    always_comb begin
        sum     = s1_prod + (s1_prod[63] ? NUDGE_NEG : NUDGE_POS);
        high    = s1_sat ? 32'sh7FFF_FFFF : sum[62:31];
        rshift  = cfg.shift[SHIFT_W-1] ? (5'd0 - cfg.shift[4:0]) : 5'd0;
        rounded = round_rshift(high, rshift);
    end

    assign unused_sum_bits = ^{sum[63], sum[30:0]};

    always_comb begin
        z      = {{2{s2_res[ACC_W-1]}}, s2_res} + {{25{cfg.out_off[OFF_W-1]}}, cfg.out_off};
        lo     = {{26{cfg.act_min[LANE_W-1]}}, cfg.act_min};
        hi     = {{26{cfg.act_max[LANE_W-1]}}, cfg.act_max};
        byte_c = z[LANE_W-1:0];
        if (z < lo) begin
            byte_c = cfg.act_min;
        end else if (z > hi) begin
            byte_c = cfg.act_max;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_sat   <= 1'b0;
            s1_prod  <= '0;
            s2_valid <= 1'b0;
            s2_last  <= 1'b0;
            s2_res   <= '0;
            s3_valid <= 1'b0;
            s3_last  <= 1'b0;
            s3_byte  <= '0;
        end else if (en) begin
            s1_valid <= in_valid;
            s1_last  <= in_last;
            s1_sat   <= sat_c;
            s1_prod  <= prod_c;
            s2_valid <= s1_valid;
            s2_last  <= s1_last;
            s2_res   <= rounded;
            s3_valid <= s2_valid;
            s3_last  <= s2_last;
            s3_byte  <= byte_c;
        end
    end

    assign out_valid  = s3_valid;
    assign out_byte   = s3_byte;
    assign out_last   = s3_last;
    assign stage_busy = s1_valid | s2_valid | s3_valid;

endmodule

`default_nettype wire

// File: rtl/requant_pack.sv
// ============================================================================
// requant_pack : int32 -> int8 requantiser packing four lanes per output word
// Rev 1.0      : initial release
// ============================================================================
`default_nettype none

module requant_pack
    import fomo_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ACC_W-1:0]        cfg_bias,
    input  logic [ACC_W-1:0]        cfg_mult,
    input  logic [SHIFT_W-1:0]      cfg_shift,
    input  logic [OFF_W-1:0]        cfg_out_off,
    input  logic [LANE_W-1:0]       cfg_act_min,
    input  logic [LANE_W-1:0]       cfg_act_max,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [ACC_W-1:0]        in_acc,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*LANE_W-1:0] out_data,
    output logic [LANES-1:0]        out_be,
    output logic                    out_last,
    output logic                    busy
);

    requant_cfg_t            cfg;
    logic                    adv;
    logic                    core_valid;
    logic [LANE_W-1:0]       core_byte;
    logic                    core_last;
    logic                    core_busy;

    logic [1:0]              lane_cnt;
    logic [LANES*LANE_W-1:0] lane_buf;
    logic [LANES*LANE_W-1:0] merged;
    logic [LANES*LANE_W-1:0] word_c;
    logic [LANES-1:0]        be_c;
    logic                    close_word;

    assign cfg.bias    = cfg_bias;
    assign cfg.mult    = cfg_mult;
    assign cfg.shift   = cfg_shift;
    assign cfg.out_off = cfg_out_off;
    assign cfg.act_min = cfg_act_min;
    assign cfg.act_max = cfg_act_max;

    // A held output word freezes the whole pipeline.
    assign adv      = !(out_valid && !out_ready);
    assign in_ready = adv;

    requant_core u_core (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (adv),
        .cfg        (cfg),
        .in_valid   (in_valid),
        .in_acc     (in_acc),
        .in_last    (in_last),
        .out_valid  (core_valid),
        .out_byte   (core_byte),
        .out_last   (core_last),
        .stage_busy (core_busy)
    );

    always_comb begin
        merged = lane_buf;
        merged[{lane_cnt, 3'b000} +: LANE_W] = core_byte;
        case (lane_cnt)
            2'd0:    be_c = 4'b0001;
            2'd1:    be_c = 4'b0011;
            2'd2:    be_c = 4'b0111;
            default: be_c = 4'b1111;
        endcase
        word_c = '0;
        for (int i = 0; i < LANES; i++) begin
            if (be_c[i]) begin
                word_c[i*LANE_W +: LANE_W] = merged[i*LANE_W +: LANE_W];
            end
        end
        close_word = (lane_cnt == 2'd3) || core_last;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_cnt  <= 2'd0;
            lane_buf  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_be    <= '0;
            out_last  <= 1'b0;
        end else if (adv) begin
            out_valid <= 1'b0;
            if (core_valid) begin
                lane_buf <= merged;
                if (close_word) begin
                    out_valid <= 1'b1;
                    out_data  <= word_c;
                    out_be    <= be_c;
                    out_last  <= core_last;
                    lane_cnt  <= 2'd0;
                end else begin
                    lane_cnt  <= lane_cnt + 2'd1;
                end
            end
        end
    end

    assign busy = core_busy | (lane_cnt != 2'd0) | out_valid;

endmodule

`default_nettype wire

// File: tb/tb_requant_pack.sv
// ============================================================================
// tb_requant_pack : directed vectors for requant_pack
// Rev 1.0         : initial release
// ============================================================================
`default_nettype none

module tb_requant_pack;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] cfg_bias = '0;
    logic [31:0] cfg_mult = '0;
    logic [5:0]  cfg_shift = '0;
    logic [8:0]  cfg_out_off = '0;
    logic [7:0]  cfg_act_min = 8'h80;
    logic [7:0]  cfg_act_max = 8'h7F;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_acc = '0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic [3:0]  out_be;
    logic        out_last;
    logic        busy;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] cyc = '0;
    logic [31:0] last_acc_cyc = '0;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  be;
        logic        last;
        logic [31:0] cyc;
    } word_t;

    word_t rx_q[$];

    requant_pack dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_bias    (cfg_bias),
        .cfg_mult    (cfg_mult),
        .cfg_shift   (cfg_shift),
        .cfg_out_off (cfg_out_off),
        .cfg_act_min (cfg_act_min),
        .cfg_act_max (cfg_act_max),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_acc      (in_acc),
        .in_last     (in_last),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_be      (out_be),
        .out_last    (out_last),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 32'd1;

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            rx_q.push_back({out_data, out_be, out_last, cyc});
        end
    end

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic timeout(input string tag);
        vectors++;
        miscompares++;
        $display("FAIL %s: got timeout expected event", tag);
    endtask

    task automatic set_cfg(input logic [31:0] bias, input logic [31:0] mult, input logic [5:0] shift,
                           input logic [8:0] off, input logic [7:0] amin, input logic [7:0] amax);
        cfg_bias    = bias;
        cfg_mult    = mult;
        cfg_shift   = shift;
        cfg_out_off = off;
        cfg_act_min = amin;
        cfg_act_max = amax;
    endtask

    // Called right after a rising edge; returns right after the accepting edge.
    task automatic send(input logic [31:0] acc, input logic last);
        int n;
        in_acc   = acc;
        in_last  = last;
        in_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 200);
        if (!in_ready) timeout("send_handshake");
        last_acc_cyc = cyc;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic get_word(output word_t w);
        int n;
        n = 0;
        while (rx_q.size() == 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (rx_q.size() == 0) begin
            timeout("word_wait");
            w = '0;
        end else begin
            w = rx_q.pop_front();
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 50);
        if (busy) timeout("idle_wait");
        @(posedge clk);
        #1;
    endtask

    task automatic single(input string tag, input logic [31:0] acc, input logic [7:0] exp);
        word_t w;
        send(acc, 1'b1);
        get_word(w);
        check_value({tag, "_data"}, w.data, {24'd0, exp});
        check_value({tag, "_be"}, {28'd0, w.be}, 32'h1);
        wait_idle();
    endtask

    initial begin
        word_t       w;
        logic [31:0] first_cyc;
        logic [31:0] held;
        int          errs;
        int          n;

        // Reset state
        #12;
        check_value("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_value("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check_value("rst_busy", {31'd0, busy}, 32'd0);
        check_value("rst_out_data", out_data, 32'd0);
        check_value("rst_out_be", {28'd0, out_be}, 32'd0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 100 * 0.5 rounds to 50, minus 128 -> 0xB2 in every lane
        set_cfg(32'd0, 32'h4000_0000, 6'd0, 9'h180, 8'h80, 8'h7F);
        send(32'd100, 1'b0);
        first_cyc = last_acc_cyc;
        send(32'd100, 1'b0);
        send(32'd100, 1'b0);
        send(32'd100, 1'b0);
        check_value("tput_cycles", last_acc_cyc - first_cyc, 32'd3);
        get_word(w);
        check_value("b2_data", w.data, 32'hB2B2_B2B2);
        check_value("b2_be", {28'd0, w.be}, 32'hF);
        check_value("b2_last", {31'd0, w.last}, 32'd0);
        check_value("b2_latency", w.cyc - last_acc_cyc, 32'd4);
        wait_idle();

        // Rounding, shifts and bias
        set_cfg(32'd0, 32'h4000_0000, 6'd0, 9'd0, 8'h80, 8'h7F);
        single("p3", 32'd3, 8'h02);
        single("m3", 32'hFFFF_FFFD, 8'hFE);
        set_cfg(32'd0, 32'h4000_0000, 6'h3F, 9'd0, 8'h80, 8'h7F);
        single("p6_r1", 32'd6, 8'h02);
        single("m5_r1", 32'hFFFF_FFFB, 8'hFE);
        set_cfg(32'd0, 32'h4000_0000, 6'd2, 9'd0, 8'h80, 8'h7F);
        single("p3_l2", 32'd3, 8'h06);
        set_cfg(32'd5, 32'h4000_0000, 6'd0, 9'd0, 8'h80, 8'h7F);
        single("bias5", 32'd3, 8'h04);
        set_cfg(32'd0, 32'h8000_0000, 6'd0, 9'd0, 8'h80, 8'h7F);
        single("sat_mul", 32'h8000_0000, 8'h7F);

        // Clamping
        set_cfg(32'd0, 32'h7FFF_FFFF, 6'd0, 9'd0, 8'h80, 8'h7F);
        single("clamp_hi", 32'd1000, 8'h7F);
        single("clamp_lo", 32'hFFFF_FC18, 8'h80);
        set_cfg(32'd0, 32'h7FFF_FFFF, 6'd0, 9'd0, 8'h00, 8'h7F);
        single("clamp_min0", 32'hFFFF_FC18, 8'h00);

        // Short row flushed by in_last, then a full row from lane 0
        set_cfg(32'd0, 32'h4000_0000, 6'd0, 9'd0, 8'h80, 8'h7F);
        send(32'd2, 1'b0);
        send(32'd4, 1'b1);
        get_word(w);
        check_value("short_data", w.data, 32'h0000_0201);
        check_value("short_be", {28'd0, w.be}, 32'h3);
        check_value("short_last", {31'd0, w.last}, 32'd1);
        send(32'd2, 1'b0);
        send(32'd4, 1'b0);
        send(32'd6, 1'b0);
        send(32'd8, 1'b0);
        get_word(w);
        check_value("after_short_data", w.data, 32'h0403_0201);
        check_value("after_short_be", {28'd0, w.be}, 32'hF);
        wait_idle();

        // Back-pressure: 16 values streamed while the sink stalls
        out_ready = 1'b0;
        errs = 0;
        held = '0;
        fork
            begin
                for (int i = 0; i < 16; i++) send(32'(i * 2), 1'b0);
            end
            begin
                n = 0;
                do begin
                    @(negedge clk);
                    n++;
                end while (!out_valid && n < 100);
                if (!out_valid) timeout("stall_first_word");
                held = out_data;
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    if (in_ready !== 1'b0 || out_data !== held || out_valid !== 1'b1) errs++;
                end
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        check_value("stall_held_word", held, 32'h0302_0100);
        check_value("stall_stable", errs, 32'd0);
        for (int j = 0; j < 4; j++) begin
            get_word(w);
            check_value($sformatf("stream_word%0d", j), w.data,
                        {8'(4*j+3), 8'(4*j+2), 8'(4*j+1), 8'(4*j)});
        end
        wait_idle();
        check_value("stream_extra", rx_q.size(), 32'd0);

        // Asynchronous reset with two lanes pending
        send(32'd2, 1'b0);
        send(32'd4, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        check_value("pre_reset_busy", {31'd0, busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_value("arst_out_data", out_data, 32'd0);
        check_value("arst_out_be", {28'd0, out_be}, 32'd0);
        check_value("arst_busy", {31'd0, busy}, 32'd0);
        check_value("arst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(32'd2, 1'b0);
        send(32'd4, 1'b0);
        send(32'd6, 1'b0);
        send(32'd8, 1'b0);
        get_word(w);
        check_value("post_reset_data", w.data, 32'h0403_0201);
        check_value("post_reset_be", {28'd0, w.be}, 32'hF);
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
